data_mem_initiator: RTL and testbench

//  Core-side initiator for the SCC data-memory port: turns single load/store requests from the CPU

---
 rtl/data_mem_initiator_pkg.sv | 16 +
 rtl/data_mem_initiator_if.sv | 28 ++
 rtl/data_mem_initiator_lane_align.sv | 16 +
 rtl/data_mem_initiator.sv | 74 +++++++
 tb/tb_data_mem_initiator.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_initiator_pkg.sv
// data_mem_initiator_pkg: size codes, FSM encoding and response constants shared by the initiator.
package data_mem_initiator_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_WAIT = 3'd1;
    localparam logic [2:0] ST_WR      = 3'd2;
    localparam logic [2:0] ST_RESP    = 3'd3;
    localparam logic [2:0] ST_ERR     = 3'd4;
    localparam logic [31:0] RSP_ZERO = 32'h0;
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
        return size == SZ_BAD || (size == SZ_HALF && lsb[0]) || (size == SZ_WORD && lsb != 2'b00);
    endfunction
endpackage

// File: rtl/data_mem_initiator_if.sv
// data_mem_initiator_if: CPU request/response handshake plus data-memory strobes.
interface data_mem_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] data_memory_a;
    logic        data_memory_read;
    logic        data_memory_write;
    logic [31:0] data_memory_out_v;
    logic [31:0] data_memory_in_v;
    modport master (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, data_memory_in_v,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
               data_memory_a, data_memory_read, data_memory_write, data_memory_out_v
    );
    modport slave (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, data_memory_in_v,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
               data_memory_a, data_memory_read, data_memory_write, data_memory_out_v
    );
endinterface

// File: rtl/data_mem_initiator_lane_align.sv
// mem_lane_align: load extract/extend and sub-word store merge on the low lanes of the memory word.
module mem_lane_align
    import data_mem_initiator_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] in_v,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] merged
);
    assign rdata = size == SZ_BYTE ? {{24{sign_ext & in_v[7]}}, in_v[7:0]}
                 : size == SZ_HALF ? {{16{sign_ext & in_v[15]}}, in_v[15:0]} : in_v;
    assign merged = size == SZ_BYTE ? {in_v[31:8], wdata[7:0]}
                  : size == SZ_HALF ? {in_v[31:16], wdata[15:0]} : wdata;
endmodule

// File: rtl/data_mem_initiator.sv
// data_mem_initiator: single-outstanding load/store initiator for the word-wide data memory.
// Strobes, address and response are registered from the next state so they change only on clk.
module data_mem_initiator
    import data_mem_initiator_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int ADDR_WIDTH   = 16
) (
    input logic clk,
    input logic reset,
    data_mem_initiator_if.master bus
);
    localparam int CW = READ_LATENCY > 1 ? $clog2(READ_LATENCY) : 1;
    logic [2:0]    state, nxt;
    logic [CW-1:0] cnt;
    logic          write_q, signed_q, idle, bad, f_signed;
    logic [1:0]    size_q, f_size;
    logic [31:0]   addr_q, wdata_q, f_addr, f_wdata, rdata, merged;
    assign idle = state == ST_IDLE;
    assign bus.req_ready = idle & ~reset;
    assign f_size = idle ? bus.req_size : size_q;
    assign f_signed = idle ? bus.req_signed : signed_q;
    assign f_addr = idle ? bus.req_addr : addr_q;
    assign f_wdata = idle ? bus.req_wdata : wdata_q;
    assign bad = misaligned(bus.req_size, bus.req_addr[1:0]) || (bus.req_addr >> ADDR_WIDTH) != 0;
    // Word stores skip the read; sub-word stores read first so the untouched lanes survive.
    assign nxt = idle ? (!bus.req_valid ? ST_IDLE : bad ? ST_ERR
                         : bus.req_write && bus.req_size == SZ_WORD ? ST_WR : ST_RD_WAIT)
               : state == ST_RD_WAIT ? (cnt != '0 ? ST_RD_WAIT : write_q ? ST_WR : ST_RESP)
               : state == ST_WR ? ST_RESP : ST_IDLE;
    mem_lane_align u_lane (
        .size(f_size),
        .sign_ext(f_signed),
        .in_v(bus.data_memory_in_v),
        .wdata(f_wdata),
        .rdata(rdata),
        .merged(merged)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt <= '0;
            write_q <= 1'b0;
            signed_q <= 1'b0;
            size_q <= SZ_BYTE;
            addr_q <= RSP_ZERO;
            wdata_q <= RSP_ZERO;
            bus.data_memory_read <= 1'b0;
            bus.data_memory_write <= 1'b0;
            bus.data_memory_a <= RSP_ZERO;
            bus.data_memory_out_v <= RSP_ZERO;
            bus.rsp_valid <= 1'b0;
            bus.rsp_error <= 1'b0;
            bus.rsp_rdata <= RSP_ZERO;
        end else begin
            state <= nxt;
            if (idle && bus.req_valid) begin
                write_q <= bus.req_write;
                signed_q <= bus.req_signed;
                size_q <= bus.req_size;
                addr_q <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            cnt <= idle ? CW'(READ_LATENCY - 1) : cnt - CW'(cnt != '0);
            bus.data_memory_read <= nxt == ST_RD_WAIT;
            bus.data_memory_write <= nxt == ST_WR;
            bus.data_memory_a <= (nxt == ST_RD_WAIT || nxt == ST_WR) ? f_addr : RSP_ZERO;
            bus.data_memory_out_v <= nxt == ST_WR ? merged : RSP_ZERO;
            bus.rsp_valid <= nxt == ST_RESP || nxt == ST_ERR;
            bus.rsp_error <= nxt == ST_ERR;
            bus.rsp_rdata <= (state == ST_RD_WAIT && nxt == ST_RESP) ? rdata : RSP_ZERO;
        end
    end
endmodule

// File: tb/tb_data_mem_initiator.sv
// tb_data_mem_initiator: random and directed load/store traffic against a byte-array reference model.
module tb_data_mem_initiator;
    import data_mem_initiator_pkg::*;
    localparam int L = 2;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    data_mem_initiator_if bus();
    data_mem_initiator #(.READ_LATENCY(L), .ADDR_WIDTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        int          cyc;
        bit          err;
        logic [31:0] rdata;
        int          nrd;
        int          nwr;
        logic [31:0] addr;
        bit          wword;
        logic [31:0] wd;
    } exp_t;
    exp_t q[$];
    logic [7:0] dmem [65536];
    logic [7:0] rmem [65536];
    int cyc = 0, n_cmp = 0, n_fail = 0, rd_n = 0, wr_n = 0, last_cyc = 0;
    logic [31:0] last_rdata = 32'h0;
    logic last_err = 1'b0;
    bit hold_cmp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: read data appears one edge after the strobe is seen, garbage otherwise.
    always @(posedge clk) begin
        logic [15:0] ma;
        ma = bus.data_memory_a[15:0];
        if (bus.data_memory_read)
            bus.data_memory_in_v <= {dmem[ma + 16'd3], dmem[ma + 16'd2], dmem[ma + 16'd1], dmem[ma]};
        else
            bus.data_memory_in_v <= $urandom;
        if (bus.data_memory_write)
            for (int i = 0; i < 4; i++) dmem[ma + 16'(i)] = bus.data_memory_out_v[8*i +: 8];
    end

    always @(negedge clk) begin
        if (!hold_cmp && !reset) begin
            rd_n += int'(bus.data_memory_read);
            wr_n += int'(bus.data_memory_write);
            chk("rw_overlap", 32'(bus.data_memory_read & bus.data_memory_write), 32'h0);
            if (!bus.data_memory_write) chk("out_v_idle", bus.data_memory_out_v, 32'h0);
            if (bus.data_memory_read || bus.data_memory_write) begin
                if (q.size() == 0) chk("stray_strobe", 32'({bus.data_memory_read, bus.data_memory_write}), 32'h0);
                else begin
                    chk("mem_addr", bus.data_memory_a, q[0].addr);
                    if (bus.data_memory_write && q[0].wword) chk("wdata", bus.data_memory_out_v, q[0].wd);
                end
            end
            if (q.size() != 0 && q[0].cyc == cyc) begin
                chk("rsp_valid", 32'(bus.rsp_valid), 32'h1);
                chk("rsp_error", 32'(bus.rsp_error), 32'(q[0].err));
                chk("rsp_rdata", bus.rsp_rdata, q[0].rdata);
                chk("n_reads", 32'(rd_n), 32'(q[0].nrd));
                chk("n_writes", 32'(wr_n), 32'(q[0].nwr));
                last_rdata = bus.rsp_rdata;
                last_err = bus.rsp_error;
                last_cyc = cyc;
                void'(q.pop_front());
                rd_n = 0;
                wr_n = 0;
            end else
                chk("rsp_idle", 32'(bus.rsp_valid) | 32'(bus.rsp_error) | bus.rsp_rdata, 32'h0);
        end
    end

    // Drive one request, predict its outcome from the byte-array model, and hand it to the checker.
    task automatic send(input bit w, input logic [1:0] sz, input bit sg, input logic [31:0] ad,
                        input logic [31:0] wd, input bit keep, output int acc);
        exp_t e;
        int n, k;
        longint v;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_size = sz;
        bus.req_signed = sg;
        bus.req_addr = ad;
        bus.req_wdata = wd;
        k = 0;
        while (!bus.req_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("ready_wait", 32'(bus.req_ready), 32'h1);
        acc = cyc;
        n = 1 << sz;
        e.err = sz == 2'b11 || (sz == 2'b01 && ad[0]) || (sz == 2'b10 && ad[1:0] != 2'b00) || ad[31:16] != 16'h0;
        e.cyc = acc + (e.err ? 1 : !w ? L + 1 : sz == 2'b10 ? 2 : L + 2);
        e.nrd = (e.err || (w && sz == 2'b10)) ? 0 : L;
        e.nwr = (!e.err && w) ? 1 : 0;
        e.addr = ad;
        e.wword = w && sz == 2'b10;
        e.wd = wd;
        e.rdata = 32'h0;
        if (!e.err && !w) begin
            v = 0;
            for (int i = 0; i < n; i++) v += longint'(rmem[ad[15:0] + 16'(i)]) << (8 * i);
            if (sg && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
            e.rdata = v[31:0];
        end
        if (!e.err && w)
            for (int i = 0; i < n; i++) rmem[ad[15:0] + 16'(i)] = wd[8*i +: 8];
        q.push_back(e);
        @(posedge clk);
        if (!keep) #1 bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("drain", 32'(q.size()), 32'h0);
        q.delete();
    endtask

    initial begin
        int acc, prev, bad_bytes, k;
        logic [31:0] ad;
        logic [1:0] sz;
        logic [7:0] b;
        for (int i = 0; i < 65536; i++) begin
            b = i < 2048 ? 8'($urandom) : 8'h0;
            dmem[i] = b;
            rmem[i] = b;
        end
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_size = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr = 32'h0;
        bus.req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 32'(bus.req_ready), 32'h0);
        chk("reset_strobes", 32'({bus.data_memory_read, bus.data_memory_write, bus.rsp_valid, bus.rsp_error}), 32'h0);
        chk("reset_addr", bus.data_memory_a, 32'h0);
        reset = 1'b0;
        #1 chk("ready_after_reset", 32'(bus.req_ready), 32'h1);

        send(1'b1, SZ_WORD, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0, acc); wait_idle();
        chk("word_store_lat", 32'(last_cyc - acc), 32'd2);
        send(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 1'b0, acc); wait_idle();
        chk("word_load_lat", 32'(last_cyc - acc), 32'd3);
        chk("word_load_data", last_rdata, 32'hDEADBEEF);
        send(1'b0, SZ_BYTE, 1'b1, 32'h101, 32'h0, 1'b0, acc); wait_idle();
        chk("byte_load_signed", last_rdata, 32'hFFFFFFBE);
        send(1'b0, SZ_BYTE, 1'b0, 32'h101, 32'h0, 1'b0, acc); wait_idle();
        chk("byte_load_unsigned", last_rdata, 32'h000000BE);
        send(1'b1, SZ_HALF, 1'b0, 32'h102, 32'h00001234, 1'b0, acc); wait_idle();
        chk("half_store_lat", 32'(last_cyc - acc), 32'd4);
        send(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 1'b0, acc); wait_idle();
        chk("half_store_merge", last_rdata, 32'h1234BEEF);
        send(1'b0, SZ_HALF, 1'b1, 32'h102, 32'h0, 1'b0, acc); wait_idle();
        chk("half_load_signed", last_rdata, 32'h00001234);
        for (int i = 0; i < 4; i++) begin
            ad = i == 0 ? 32'h102 : i == 1 ? 32'h1 : i == 2 ? 32'h100 : 32'h00010000;
            sz = i == 0 ? SZ_WORD : i == 1 ? SZ_HALF : i == 2 ? SZ_BAD : SZ_WORD;
            send(1'(i & 1), sz, 1'b0, ad, 32'hFFFFFFFF, 1'b0, acc); wait_idle();
            chk("err_lat", 32'(last_cyc - acc), 32'd1);
            chk("err_flag", 32'(last_err), 32'h1);
        end

        // Reset in the read phase of a byte store must leave memory untouched.
        hold_cmp = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size = SZ_BYTE;
        bus.req_addr = 32'h105;
        bus.req_wdata = {24'h0, ~rmem[16'h105]};
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (!bus.data_memory_read && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rst_saw_read", 32'(bus.data_memory_read), 32'h1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_strobes", 32'({bus.data_memory_read, bus.data_memory_write, bus.rsp_valid, bus.req_ready}), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'h1);
        rd_n = 0;
        wr_n = 0;
        hold_cmp = 1'b0;
        repeat (4) @(negedge clk);

        prev = 0;
        for (int i = 0; i < 8; i++) begin
            send(1'b0, SZ_WORD, 1'(i & 1), 32'h200 + 32'(4 * i), 32'h0, i != 7, acc);
            if (i != 0) chk("b2b_spacing", 32'(acc - prev), 32'(L + 2));
            prev = acc;
        end
        wait_idle();

        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 15);
            sz = k == 0 ? SZ_BAD : 2'(k % 3);
            ad = 32'($urandom_range(0, 2043));
            if (sz != SZ_BAD && $urandom_range(0, 3) != 0) ad = ad & ~((32'h1 << sz) - 32'h1);
            if ($urandom_range(0, 19) == 0) ad = ad | (32'h1 << $urandom_range(16, 31));
            send(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom, 1'b1, acc);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                bus.req_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);

        bad_bytes = 0;
        for (int i = 0; i < 2048 + 4; i++) if (dmem[i] !== rmem[i]) bad_bytes++;
        chk("mem_image", 32'(bad_bytes), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end
endmodule
